// File: rtl/pc_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_pkg
// Description : Shared types and default parameters for the PC / instruction
//               fetch sequencer and its optional performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_fetch_pkg;

  // Default configuration values for pc_fetch_unit.
  localparam int unsigned c_def_addr_w   = 16;
  localparam int unsigned c_def_instr_w  = 16;
  localparam int unsigned c_def_reset_pc = 0;

  // Width of each optional performance counter.
  localparam int unsigned c_perf_cnt_w   = 16;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } fetch_state_t;

endpackage : pc_fetch_pkg
`default_nettype wire

// File: rtl/pc_fetch_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_perf_cnt
// Description : Pair of saturating event counters for the fetch unit.
//               Only built when PC_FETCH_PERF_CNT_EN is defined.
// Ports       : clk, rst_n        - clock, async active-low reset
//               fetch_evt         - one instruction handshake this cycle
//               redirect_evt      - one redirect cycle (outside S_IDLE)
//               fetch_cnt         - saturating count of fetch_evt
//               redirect_cnt      - saturating count of redirect_evt
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_perf_cnt
  import pc_fetch_pkg::*;
#(
  parameter int unsigned CNT_W = c_perf_cnt_w
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_evt,
  input  logic             redirect_evt,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  logic [CNT_W-1:0] r_fetch_cnt;
  logic [CNT_W-1:0] r_redirect_cnt;

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt    <= '0;
      r_redirect_cnt <= '0;
    end else begin
      if (fetch_evt && (r_fetch_cnt != '1)) begin
        r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
      end
      if (redirect_evt && (r_redirect_cnt != '1)) begin
        r_redirect_cnt <= r_redirect_cnt + CNT_W'(1);
      end
    end
  end

  assign fetch_cnt    = r_fetch_cnt;
  assign redirect_cnt = r_redirect_cnt;

endmodule : pc_fetch_perf_cnt
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Program counter and single-outstanding instruction fetch
//               sequencer. Issues one memory request at a time, hands each
//               fetched word to decode over valid/ready, and squashes
//               wrong-path work when pc_write_enabled redirects the PC.
// Ports       : clk, rst_n                  - clock, async active-low reset
//               pc_write_enabled, branch_target - redirect from branch compare
//               imem_req_valid/ready/addr    - fetch request channel
//               imem_rsp_valid/data          - fetch response channel
//               instr_valid/ready/data/pc    - decode channel
//               perf_fetch_cnt, perf_redirect_cnt (only with macro below)
// Config      : define PC_FETCH_PERF_CNT_EN to add the performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = c_def_addr_w,
  parameter int unsigned INSTR_W  = c_def_instr_w,
  parameter int unsigned RESET_PC = c_def_reset_pc
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pc_write_enabled,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc
`ifdef PC_FETCH_PERF_CNT_EN
  ,
  output logic [c_perf_cnt_w-1:0] perf_fetch_cnt,
  output logic [c_perf_cnt_w-1:0] perf_redirect_cnt
`endif
);

  localparam logic [ADDR_W-1:0] c_reset_pc = ADDR_W'(RESET_PC);

  fetch_state_t       r_state;
  fetch_state_t       w_state_nxt;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_pc_nxt;
  logic               r_drop;
  logic               w_drop_nxt;
  logic [INSTR_W-1:0] r_instr_data;
  logic [INSTR_W-1:0] w_instr_data_nxt;
  logic [ADDR_W-1:0]  r_instr_pc;
  logic [ADDR_W-1:0]  w_instr_pc_nxt;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= c_reset_pc;
      r_drop       <= 1'b0;
      r_instr_data <= '0;
      r_instr_pc   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_drop       <= w_drop_nxt;
      r_instr_data <= w_instr_data_nxt;
      r_instr_pc   <= w_instr_pc_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and handshake outputs. Both valids are masked by the redirect
  // input combinationally so nothing on the wrong path transfers in the
  // redirect cycle itself.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_drop_nxt       = r_drop;
    w_instr_data_nxt = r_instr_data;
    w_instr_pc_nxt   = r_instr_pc;
    imem_req_valid   = 1'b0;
    instr_valid      = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Redirects are ignored here; the first fetch always starts at reset PC.
        w_state_nxt = S_REQ;
      end

      S_REQ: begin
        imem_req_valid = !pc_write_enabled;
        if (pc_write_enabled) begin
          w_pc_nxt = branch_target;
        end else if (imem_req_ready) begin
          w_state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (imem_rsp_valid) begin
          w_drop_nxt = 1'b0;
          if (pc_write_enabled) begin
            // Response lands in the redirect cycle: discard it, fetch target.
            w_pc_nxt    = branch_target;
            w_state_nxt = S_REQ;
          end else if (r_drop) begin
            // Stale response from before an earlier redirect; pc already
            // holds the target.
            w_state_nxt = S_REQ;
          end else begin
            w_instr_data_nxt = imem_rsp_data;
            w_instr_pc_nxt   = r_pc;
            w_pc_nxt         = r_pc + ADDR_W'(1);
            w_state_nxt      = S_OUT;
          end
        end else if (pc_write_enabled) begin
          // Request still in flight: remember to throw its response away.
          w_drop_nxt = 1'b1;
          w_pc_nxt   = branch_target;
        end
      end

      S_OUT: begin
        instr_valid = !pc_write_enabled;
        if (pc_write_enabled) begin
          w_pc_nxt    = branch_target;
          w_state_nxt = S_REQ;
        end else if (instr_ready) begin
          w_state_nxt = S_REQ;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign imem_req_addr = r_pc;
  assign instr_data    = r_instr_data;
  assign instr_pc      = r_instr_pc;

  // --------------------------------------------------------------------------
  // Optional performance counters
  // --------------------------------------------------------------------------
`ifdef PC_FETCH_PERF_CNT_EN
  pc_fetch_perf_cnt #(
    .CNT_W (c_perf_cnt_w)
  ) u_perf_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_evt    (instr_valid && instr_ready),
    .redirect_evt (pc_write_enabled && (r_state != S_IDLE)),
    .fetch_cnt    (perf_fetch_cnt),
    .redirect_cnt (perf_redirect_cnt)
  );
`else
  // No performance counters in this build.
`endif

endmodule : pc_fetch_unit
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Self-checking bench for pc_fetch_unit. A memory responder and
//               random decode/redirect driver feed the DUT; a transaction
//               model predicts the fetch address stream and the instructions
//               decode must receive, and a monitor compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;
  import pc_fetch_pkg::*;

  localparam int unsigned TB_RESET_PC = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_write_enabled = 1'b0;
  logic [15:0] branch_target = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [15:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [15:0] imem_rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr_data;
  logic [15:0] instr_pc;
`ifdef PC_FETCH_PERF_CNT_EN
  logic [15:0] perf_fetch_cnt;
  logic [15:0] perf_redirect_cnt;
`endif

  always #5 clk = ~clk;

  pc_fetch_unit #(
    .ADDR_W   (16),
    .INSTR_W  (16),
    .RESET_PC (TB_RESET_PC)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_write_enabled (pc_write_enabled),
    .branch_target    (branch_target),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr_data       (instr_data),
    .instr_pc         (instr_pc)
`ifdef PC_FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt    (perf_fetch_cnt),
    .perf_redirect_cnt (perf_redirect_cnt)
`endif
  );

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] data;
  } item_t;

  int    n_checks = 0;
  int    n_err    = 0;
  item_t exp_q[$];
  item_t mon_it;

  // Reference model: next program-order fetch address and in-flight request.
  logic [15:0] model_pc  = 16'(TB_RESET_PC);
  bit          model_idle = 1'b0;
  bit          live       = 1'b0;
  bit          mem_busy   = 1'b0;
  int          mem_wait   = 0;
  logic [15:0] mem_addr   = '0;

  // Stimulus knobs.
  int          p_pwe = 0, p_req_rdy = 100, p_dec_rdy = 100, max_wait = 0;
  bit          phase_ideal = 1'b0;
  bit          redir_in_wait = 1'b0, redir_on_rsp = 1'b0, redir_now = 1'b0;
  logic [15:0] redir_tgt = '0;

  // Monitor history.
  int          cyc = 0, last_req_cyc = -1, n_deliv = 0;
  bit          wrap_seen = 1'b0, last_deliv_ok = 1'b0;
  logic [15:0] last_deliv_pc = '0;
  bit          prev_held = 1'b0, prev_pwe = 1'b0, exp_valid_next = 1'b0;
  logic [15:0] prev_data = '0, prev_pc = '0;
  int          m_fetch = 0, m_redir = 0;

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(imem_req_valid == 1'b0, {tag, "_req_valid"}, 32'(imem_req_valid), 32'h0);
    chk(instr_valid == 1'b0, {tag, "_instr_valid"}, 32'(instr_valid), 32'h0);
    chk(instr_data == 16'h0, {tag, "_instr_data"}, 32'(instr_data), 32'h0);
    chk(instr_pc == 16'h0, {tag, "_instr_pc"}, 32'(instr_pc), 32'h0);
    chk(imem_req_addr == 16'(TB_RESET_PC), {tag, "_req_addr"}, 32'(imem_req_addr), TB_RESET_PC);
  endtask

  function automatic logic [15:0] pick_target();
    case ($urandom_range(0, 3))
      0:       return 16'h0040;
      1:       return 16'h0100;
      2:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // One clock of stimulus: memory responder, decode ready, redirects.
  task automatic drive_cycle();
    @(posedge clk);
    #1;
    imem_rsp_valid   = 1'b0;
    pc_write_enabled = 1'b0;
    if (mem_busy) begin
      if (mem_wait == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 16'($urandom);
        mem_busy       = 1'b0;
      end else begin
        mem_wait--;
      end
    end
    imem_req_ready = ($urandom_range(0, 99) < p_req_rdy);
    instr_ready    = ($urandom_range(0, 99) < p_dec_rdy);
    branch_target  = 16'($urandom);
    if (redir_on_rsp && imem_rsp_valid) begin
      pc_write_enabled = 1'b1;
      branch_target    = 16'h0100;
      redir_on_rsp     = 1'b0;
    end else if (redir_in_wait && mem_busy) begin
      pc_write_enabled = 1'b1;
      branch_target    = 16'h0040;
      mem_wait         = 2;
      redir_in_wait    = 1'b0;
    end else if (redir_now) begin
      pc_write_enabled = 1'b1;
      branch_target    = redir_tgt;
      redir_now        = 1'b0;
    end else if ($urandom_range(0, 99) < p_pwe) begin
      pc_write_enabled = 1'b1;
      branch_target    = pick_target();
    end
  endtask

  // Monitor + model update, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_held      = 1'b0;
      exp_valid_next = 1'b0;
    end else if (model_idle) begin
      chk(!imem_req_valid && !instr_valid, "idle_quiet",
          {30'h0, imem_req_valid, instr_valid}, 32'h0);
      model_idle     = 1'b0;
      prev_held      = 1'b0;
      prev_pwe       = 1'b0;
      exp_valid_next = 1'b0;
    end else begin
      if (pc_write_enabled) begin
        chk(!imem_req_valid, "redir_gate_req", 32'(imem_req_valid), 32'h0);
        chk(!instr_valid, "redir_gate_instr", 32'(instr_valid), 32'h0);
      end
      if (exp_valid_next)
        chk(instr_valid || pc_write_enabled, "valid_latency", 32'(instr_valid), 32'h1);
      if (prev_held && !prev_pwe) begin
        chk(instr_valid || pc_write_enabled, "hold_valid", 32'(instr_valid), 32'h1);
        chk(instr_data == prev_data && instr_pc == prev_pc, "hold_stable",
            {instr_pc, instr_data}, {prev_pc, prev_data});
      end
      exp_valid_next = 1'b0;

      if (imem_req_valid)
        chk(exp_q.size() == 0, "req_while_held", 32'(exp_q.size()), 32'h0);

      if (imem_req_valid && imem_req_ready) begin
        chk(imem_req_addr == model_pc, "req_addr", 32'(imem_req_addr), 32'(model_pc));
        chk(!mem_busy, "one_outstanding", 32'(mem_busy), 32'h0);
        if (phase_ideal && last_req_cyc >= 0)
          chk(cyc - last_req_cyc == 3, "fetch_period", 32'(cyc - last_req_cyc), 32'h3);
        last_req_cyc = cyc;
        if (imem_req_addr == 16'h0000 && last_deliv_ok && last_deliv_pc == 16'hFFFF)
          wrap_seen = 1'b1;
        mem_busy = 1'b1;
        mem_wait = $urandom_range(0, max_wait);
        mem_addr = imem_req_addr;
        live     = 1'b1;
      end

      if (imem_rsp_valid) begin
        if (live && !pc_write_enabled) begin
          mon_it.pc   = mem_addr;
          mon_it.data = imem_rsp_data;
          exp_q.push_back(mon_it);
          model_pc       = 16'(mem_addr + 16'd1);
          exp_valid_next = 1'b1;
        end
        live = 1'b0;
      end

      if (instr_valid && instr_ready) begin
        m_fetch++;
        chk(exp_q.size() != 0, "instr_expected", 32'(instr_pc), 32'(exp_q.size()));
        if (exp_q.size() != 0) begin
          mon_it = exp_q.pop_front();
          chk(instr_pc == mon_it.pc, "instr_pc", 32'(instr_pc), 32'(mon_it.pc));
          chk(instr_data == mon_it.data, "instr_data", 32'(instr_data), 32'(mon_it.data));
          n_deliv++;
          last_deliv_pc = instr_pc;
          last_deliv_ok = 1'b1;
        end
      end

      prev_held = instr_valid && !instr_ready;
      prev_data = instr_data;
      prev_pc   = instr_pc;
      prev_pwe  = pc_write_enabled;

      if (pc_write_enabled) begin
        m_redir++;
        model_pc      = branch_target;
        live          = 1'b0;
        last_deliv_ok = 1'b0;
        exp_q.delete();
      end
    end
  end

  initial begin
    int k;
    // Power-on reset.
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    rst_n      = 1'b1;
    model_idle = 1'b1;
    // A redirect during the idle cycle must be ignored.
    pc_write_enabled = 1'b1;
    branch_target    = 16'h1234;

    // Ideal memory and decode: back-to-back 3-cycle fetches from reset PC.
    phase_ideal = 1'b1;
    repeat (30) drive_cycle();
    phase_ideal = 1'b0;

    // Decode back-pressure and memory latency.
    p_dec_rdy = 20; max_wait = 2;
    repeat (200) drive_cycle();

    // Redirect while waiting, response three cycles later.
    p_dec_rdy = 80;
    redir_in_wait = 1'b1;
    repeat (25) drive_cycle();

    // Redirect coinciding with a response.
    redir_on_rsp = 1'b1;
    repeat (25) drive_cycle();

    // Redirect to top of address space, then fetch across the wrap.
    p_dec_rdy = 100; max_wait = 0;
    redir_now = 1'b1; redir_tgt = 16'hFFFF;
    repeat (30) drive_cycle();

    // Fully random traffic.
    p_pwe = 8; p_req_rdy = 70; p_dec_rdy = 70; max_wait = 3;
    repeat (2000) drive_cycle();

    // Reset while a request is outstanding.
    p_pwe = 0; p_req_rdy = 100; max_wait = 3;
    k = 0;
    while (!mem_busy && k < 50) begin
      drive_cycle();
      k++;
    end
    chk(mem_busy, "reach_wait", 32'(mem_busy), 32'h1);
    #2;
    rst_n            = 1'b0;
    pc_write_enabled = 1'b0;
    imem_rsp_valid   = 1'b0;
    mem_busy         = 1'b0;
    live             = 1'b0;
    exp_q.delete();
    model_pc      = 16'(TB_RESET_PC);
    last_deliv_ok = 1'b0;
    m_fetch       = 0;
    m_redir       = 0;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n      = 1'b1;
    model_idle = 1'b1;
    // Stale response to the pre-reset request.
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 16'hDEAD;
    p_dec_rdy = 100; max_wait = 0;
    phase_ideal = 1'b1; last_req_cyc = -1;
    repeat (30) drive_cycle();
    phase_ideal = 1'b0;

    chk(n_deliv >= 60, "progress", 32'(n_deliv), 32'd60);
    chk(wrap_seen, "wrap_ffff_to_0", 32'(wrap_seen), 32'h1);
`ifdef PC_FETCH_PERF_CNT_EN
    chk(perf_fetch_cnt == 16'(m_fetch), "perf_fetch_cnt", 32'(perf_fetch_cnt), 32'(m_fetch));
    chk(perf_redirect_cnt == 16'(m_redir), "perf_redirect_cnt",
        32'(perf_redirect_cnt), 32'(m_redir));
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_pc_fetch_unit
`default_nettype wire
